codma_chain_checker: RTL and testbench



---
 rtl/codma_chk_pkg.sv | 46 ++++
 rtl/codma_chk_dual_read.sv | 84 ++++++++
 rtl/codma_chain_checker.sv | 253 +++++++++++++++++++++++++
 tb/tb_codma_chain_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/codma_chk_pkg.sv
// Shared types for the codma chain checker: FSM states, error codes,
// descriptor task types and descriptor field positions.
package codma_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_VALIDATE,
    ST_CMP,
    ST_NEXT,
    ST_STATUS,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_MISMATCH = 3'd1,
    ERR_BAD_TYPE = 3'd2,
    ERR_MISALIGN = 3'd3,
    ERR_TOO_LONG = 3'd4,
    ERR_STATUS   = 3'd5
  } err_e;

  localparam logic [31:0] TASK_SINGLE = 32'd0;
  localparam logic [31:0] TASK_BURST  = 32'd1;
  localparam logic [31:0] TASK_LINK   = 32'd2;

  // word0 = {src, type}, word1 = {len, dst}
  localparam int W0_TYPE_LSB = 0;
  localparam int W0_SRC_LSB  = 32;
  localparam int W1_DST_LSB  = 0;
  localparam int W1_LEN_LSB  = 32;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] ttype;
    logic [31:0] len;
    logic [31:0] dst;
  } desc_t;

  function automatic logic [31:0] field32(input logic [63:0] w, input int lsb);
    return w[lsb +: 32];
  endfunction

endpackage

// File: rtl/codma_chk_dual_read.sv
// Paired live/snapshot read engine: one outstanding read per port, valids
// captured in either order, single pair_valid pulse once both are in hand.
module codma_chk_dual_read #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          issue_i,
  input  logic          use_snap_i,
  input  logic [31:0]   live_addr_i,
  input  logic [31:0]   snap_addr_i,
  output logic          live_req_o,
  output logic [31:0]   live_addr_o,
  input  logic          live_valid_i,
  input  logic [DW-1:0] live_data_i,
  output logic          snap_req_o,
  output logic [31:0]   snap_addr_o,
  input  logic          snap_valid_i,
  input  logic [DW-1:0] snap_data_i,
  output logic          pair_valid_o,
  output logic [DW-1:0] live_data_o,
  output logic [DW-1:0] snap_data_o
);

  logic          live_req_q, snap_req_q, live_got_q, snap_got_q, pair_valid_q;
  logic [31:0]   live_addr_q, snap_addr_q;
  logic [DW-1:0] live_hold_q, snap_hold_q;
  logic          live_cap, snap_cap, fire;

  // A valid only counts while its request is up; stray valids fall through.
  assign live_cap = live_req_q & live_valid_i;
  assign snap_cap = snap_req_q & snap_valid_i;
  assign fire     = (live_got_q | live_cap) & (snap_got_q | snap_cap);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      live_req_q   <= 1'b0;
      snap_req_q   <= 1'b0;
      live_got_q   <= 1'b0;
      snap_got_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      live_addr_q  <= '0;
      snap_addr_q  <= '0;
      live_hold_q  <= '0;
      snap_hold_q  <= '0;
    end else begin
      pair_valid_q <= 1'b0;
      if (issue_i) begin
        live_req_q  <= 1'b1;
        snap_req_q  <= use_snap_i;
        live_addr_q <= live_addr_i;
        snap_addr_q <= snap_addr_i;
        live_got_q  <= 1'b0;
        // live-only reads treat the snapshot side as already satisfied
        snap_got_q  <= ~use_snap_i;
      end else begin
        if (live_cap) begin
          live_req_q  <= 1'b0;
          live_got_q  <= 1'b1;
          live_hold_q <= live_data_i;
        end
        if (snap_cap) begin
          snap_req_q  <= 1'b0;
          snap_got_q  <= 1'b1;
          snap_hold_q <= snap_data_i;
        end
        if (fire) begin
          live_got_q   <= 1'b0;
          snap_got_q   <= 1'b0;
          pair_valid_q <= 1'b1;
        end
      end
    end
  end

  assign live_req_o   = live_req_q;
  assign live_addr_o  = live_addr_q;
  assign snap_req_o   = snap_req_q;
  assign snap_addr_o  = snap_addr_q;
  assign pair_valid_o = pair_valid_q;
  assign live_data_o  = live_hold_q;
  assign snap_data_o  = snap_hold_q;

endmodule

// File: rtl/codma_chain_checker.sv
// Walks a codma descriptor chain, compares live vs snapshot regions, checks
// the DMA status word. CODMA_CHK_STOP_ON_FAIL_EN: first error ends the run.
module codma_chain_checker
  import codma_chk_pkg::*;
#(
  parameter int MEM_DEPTH         = 32,
  parameter int MEM_WIDTH         = 8,
  parameter int MAX_LINKS         = 8,
  parameter int LINK_OFFSET_WORDS = 4,
  parameter int CNT_W             = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic [31:0]            task_pointer_i,
  input  logic [31:0]            status_pointer_i,
  output logic                   live_req_o,
  output logic [31:0]            live_addr_o,
  input  logic                   live_valid_i,
  input  logic [MEM_WIDTH*8-1:0] live_data_i,
  output logic                   snap_req_o,
  output logic [31:0]            snap_addr_o,
  input  logic                   snap_valid_i,
  input  logic [MEM_WIDTH*8-1:0] snap_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [2:0]             err_code_o,
  output logic [31:0]            fail_addr_o,
  output logic [CNT_W-1:0]       fail_count_o,
  output logic [7:0]             tasks_checked_o
);

  localparam int          DW        = MEM_WIDTH * 8;
  localparam logic [31:0] WB        = 32'(MEM_WIDTH);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * MEM_WIDTH);
  localparam logic [31:0] LINK_OFS  = 32'(LINK_OFFSET_WORDS);
`ifdef CODMA_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  if (MEM_WIDTH < 8) begin : g_width_chk
    $error("codma_chain_checker: MEM_WIDTH must be >= 8");
  end

  state_e           state_q, state_d;
  err_e             err_code_q, err_code_d;
  desc_t            desc_q, desc_d;
  logic [31:0]      desc_idx_q, desc_idx_d, status_ptr_q, status_ptr_d;
  logic [31:0]      src_idx_q, src_idx_d, dst_idx_q, dst_idx_d, left_q, left_d;
  logic [31:0]      fail_addr_q, fail_addr_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic [7:0]       tasks_q, tasks_d;
  logic             expect_err_q, expect_err_d, pass_q, pass_d, rd_out_q, rd_out_d;

  logic             rd_issue, rd_use_snap, pair_valid, range_bad, bad_type, misaligned;
  logic [31:0]      rd_live_addr, rd_snap_addr;
  logic [DW-1:0]    rd_live_data, rd_snap_data;

  codma_chk_dual_read #(.DW(DW)) u_rd (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_i      (rd_issue),
    .use_snap_i   (rd_use_snap),
    .live_addr_i  (rd_live_addr),
    .snap_addr_i  (rd_snap_addr),
    .live_req_o   (live_req_o),
    .live_addr_o  (live_addr_o),
    .live_valid_i (live_valid_i),
    .live_data_i  (live_data_i),
    .snap_req_o   (snap_req_o),
    .snap_addr_o  (snap_addr_o),
    .snap_valid_i (snap_valid_i),
    .snap_data_i  (snap_data_i),
    .pair_valid_o (pair_valid),
    .live_data_o  (rd_live_data),
    .snap_data_o  (rd_snap_data)
  );

  assign range_bad  = (({1'b0, desc_q.src} + {1'b0, desc_q.len}) > MEM_BYTES) ||
                      (({1'b0, desc_q.dst} + {1'b0, desc_q.len}) > MEM_BYTES);
  assign bad_type   = !(desc_q.ttype == TASK_SINGLE || desc_q.ttype == TASK_BURST ||
                        desc_q.ttype == TASK_LINK);
  assign misaligned = ((desc_q.src % WB) != 32'd0) || ((desc_q.dst % WB) != 32'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      err_code_q   <= ERR_NONE;
      desc_q       <= '0;
      desc_idx_q   <= '0;
      status_ptr_q <= '0;
      src_idx_q    <= '0;
      dst_idx_q    <= '0;
      left_q       <= '0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
      tasks_q      <= '0;
      expect_err_q <= 1'b0;
      pass_q       <= 1'b0;
      rd_out_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      desc_q       <= desc_d;
      desc_idx_q   <= desc_idx_d;
      status_ptr_q <= status_ptr_d;
      src_idx_q    <= src_idx_d;
      dst_idx_q    <= dst_idx_d;
      left_q       <= left_d;
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
      tasks_q      <= tasks_d;
      expect_err_q <= expect_err_d;
      pass_q       <= pass_d;
      rd_out_q     <= rd_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    desc_d       = desc_q;
    desc_idx_d   = desc_idx_q;
    status_ptr_d = status_ptr_q;
    src_idx_d    = src_idx_q;
    dst_idx_d    = dst_idx_q;
    left_d       = left_q;
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;
    tasks_d      = tasks_q;
    expect_err_d = expect_err_q;
    pass_d       = pass_q;
    rd_issue     = 1'b0;
    rd_use_snap  = 1'b0;
    rd_live_addr = desc_idx_q;
    rd_snap_addr = src_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_FETCH0;
          desc_idx_d   = task_pointer_i / WB;
          status_ptr_d = status_pointer_i;
          err_code_d   = ERR_NONE;
          fail_addr_d  = '0;
          fail_count_d = '0;
          tasks_d      = '0;
          expect_err_d = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_FETCH0: begin
        rd_issue = !rd_out_q;
        if (pair_valid) begin
          desc_d.src   = field32(rd_live_data[63:0], W0_SRC_LSB);
          desc_d.ttype = field32(rd_live_data[63:0], W0_TYPE_LSB);
          state_d      = ST_FETCH1;
        end
      end
      ST_FETCH1: begin
        rd_live_addr = desc_idx_q + 32'd1;
        rd_issue     = !rd_out_q;
        if (pair_valid) begin
          desc_d.len = field32(rd_live_data[63:0], W1_LEN_LSB);
          desc_d.dst = field32(rd_live_data[63:0], W1_DST_LSB);
          state_d    = ST_VALIDATE;
        end
      end
      ST_VALIDATE: begin
        tasks_d   = tasks_q + 8'd1;
        src_idx_d = desc_q.src / WB;
        dst_idx_d = desc_q.dst / WB;
        left_d    = desc_q.len / WB;
        if (range_bad) expect_err_d = 1'b1;
        if (bad_type || misaligned) begin
          if (err_code_q == ERR_NONE) begin
            err_code_d  = bad_type ? ERR_BAD_TYPE : ERR_MISALIGN;
            fail_addr_d = desc_idx_q;
          end
          state_d = STOP_ON_FAIL ? ST_DONE : ST_STATUS;
        end else if (range_bad || left_d == 32'd0) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        rd_live_addr = dst_idx_q;
        rd_use_snap  = 1'b1;
        rd_issue     = !rd_out_q;
        if (pair_valid) begin
          src_idx_d = src_idx_q + 32'd1;
          dst_idx_d = dst_idx_q + 32'd1;
          left_d    = left_q - 32'd1;
          if (left_q == 32'd1) state_d = ST_NEXT;
          if (rd_live_data != rd_snap_data) begin
            if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_W'(1);
            if (err_code_q == ERR_NONE) begin
              err_code_d  = ERR_MISMATCH;
              fail_addr_d = dst_idx_q;
            end
            if (STOP_ON_FAIL) state_d = ST_DONE;
          end
        end
      end
      ST_NEXT: begin
        if (desc_q.ttype == TASK_LINK) begin
          if (tasks_q >= 8'(MAX_LINKS)) begin
            if (err_code_q == ERR_NONE) begin
              err_code_d  = ERR_TOO_LONG;
              fail_addr_d = desc_idx_q + LINK_OFS;
            end
            state_d = STOP_ON_FAIL ? ST_DONE : ST_STATUS;
          end else begin
            desc_idx_d = desc_idx_q + LINK_OFS;
            state_d    = ST_FETCH0;
          end
        end else begin
          state_d = ST_STATUS;
        end
      end
      ST_STATUS: begin
        rd_live_addr = status_ptr_q;
        rd_issue     = !rd_out_q;
        if (pair_valid) begin
          // a run that touched out-of-range descriptors must report status 1
          if (rd_live_data != DW'(expect_err_q) && err_code_q == ERR_NONE) begin
            err_code_d  = ERR_STATUS;
            fail_addr_d = status_ptr_q;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_out_d = rd_issue ? 1'b1 : (pair_valid ? 1'b0 : rd_out_q);
    if (state_d == ST_DONE && state_q != ST_DONE) pass_d = (err_code_d == ERR_NONE);
  end

  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign pass_o          = pass_q;
  assign err_code_o      = err_code_q;
  assign fail_addr_o     = fail_addr_q;
  assign fail_count_o    = fail_count_q;
  assign tasks_checked_o = tasks_q;

endmodule

// File: tb/tb_codma_chain_checker.sv
// Directed bench for codma_chain_checker with live/snapshot memory responders.
module tb_codma_chain_checker;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0, start_i = 1'b0;
  logic [31:0]   task_pointer_i = '0, status_pointer_i = '0;
  logic          live_req_o, snap_req_o, live_valid_i, snap_valid_i;
  logic [31:0]   live_addr_o, snap_addr_o, fail_addr_o;
  logic [DW-1:0] live_data_i, snap_data_i;
  logic          busy_o, done_o, pass_o;
  logic [2:0]    err_code_o;
  logic [15:0]   fail_count_o;
  logic [7:0]    tasks_checked_o;

  codma_chain_checker dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .task_pointer_i(task_pointer_i), .status_pointer_i(status_pointer_i),
    .live_req_o(live_req_o), .live_addr_o(live_addr_o),
    .live_valid_i(live_valid_i), .live_data_i(live_data_i),
    .snap_req_o(snap_req_o), .snap_addr_o(snap_addr_o),
    .snap_valid_i(snap_valid_i), .snap_data_i(snap_data_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_code_o(err_code_o),
    .fail_addr_o(fail_addr_o), .fail_count_o(fail_count_o),
    .tasks_checked_o(tasks_checked_o)
  );

  logic [63:0] live_mem [32];
  logic [63:0] snap_mem [32];
  int fixed_dly = 0;
  bit skew = 1'b0;
  int n_chk = 0, n_pass = 0;

  // memory responders: wait a programmable delay after req, return one valid
  bit l_busy, s_busy, snap_req_prev;
  int l_cnt, s_cnt, snap_reqs = 0;
  always @(posedge clk) begin
    live_valid_i <= 1'b0;
    if (!reset_n) l_busy <= 1'b0;
    else if (l_busy) begin
      if (l_cnt == 0) begin
        live_valid_i <= 1'b1;
        live_data_i  <= live_mem[live_addr_o[4:0]];
        l_busy       <= 1'b0;
      end else l_cnt <= l_cnt - 1;
    end else if (live_req_o && !live_valid_i) begin
      l_busy <= 1'b1;
      l_cnt  <= skew ? int'($urandom_range(4, 0)) : fixed_dly;
    end
  end
  always @(posedge clk) begin
    snap_valid_i <= 1'b0;
    if (!reset_n) s_busy <= 1'b0;
    else if (s_busy) begin
      if (s_cnt == 0) begin
        snap_valid_i <= 1'b1;
        snap_data_i  <= snap_mem[snap_addr_o[4:0]];
        s_busy       <= 1'b0;
      end else s_cnt <= s_cnt - 1;
    end else if (snap_req_o && !snap_valid_i) begin
      s_busy <= 1'b1;
      s_cnt  <= skew ? int'($urandom_range(4, 0)) : fixed_dly;
    end
  end
  always @(posedge clk) begin
    snap_req_prev <= snap_req_o;
    if (snap_req_o && !snap_req_prev) snap_reqs <= snap_reqs + 1;
  end

  task automatic init_mem();
    for (int i = 0; i < 32; i++) begin
      live_mem[i] = 64'h1111_0000_0000_0000 | 64'(i);
      snap_mem[i] = 64'h2222_0000_0000_0000 | 64'(i);
    end
    live_mem[31] = 64'd0;
  endtask

  task automatic put_desc(input int w, input logic [31:0] typ, src, len, dst);
    live_mem[w]     = {src, typ};
    live_mem[w + 1] = {len, dst};
  endtask

  task automatic copy_words(input int sw, input int dw, input int n);
    for (int i = 0; i < n; i++) live_mem[dw + i] = snap_mem[sw + i];
  endtask

  task automatic run(input logic [31:0] tp, input logic [31:0] sp, output bit ok);
    @(negedge clk);
    task_pointer_i = tp; status_pointer_i = sp; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic setup_case1();
    init_mem();
    put_desc(0, 32'd0, 32'h10, 32'd16, 32'h80);
    copy_words(2, 16, 2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({busy_o, done_o, pass_o, live_req_o, snap_req_o} !== 5'b0)
      $display("FAIL rst_ctrl: got %b want 00000", {busy_o, done_o, pass_o, live_req_o, snap_req_o}); else n_pass++;
    n_chk++; if (err_code_o !== 3'd0) $display("FAIL rst_err: got %0d want 0", err_code_o); else n_pass++;
    n_chk++; if (fail_count_o !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", fail_count_o); else n_pass++;
    n_chk++; if (tasks_checked_o !== 8'd0) $display("FAIL rst_tasks: got %0d want 0", tasks_checked_o); else n_pass++;
    n_chk++; if (fail_addr_o !== 32'd0) $display("FAIL rst_addr: got %0h want 0", fail_addr_o); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok; int s0;
    setup_case1(); fixed_dly = 1; skew = 1'b0;
    s0 = snap_reqs;
    run(32'h0, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t1_done: no done_o within budget"); else n_pass++;
    n_chk++; if (pass_o !== 1'b1) $display("FAIL t1_pass: got %b want 1", pass_o); else n_pass++;
    n_chk++; if (err_code_o !== 3'd0) $display("FAIL t1_err: got %0d want 0", err_code_o); else n_pass++;
    n_chk++; if (tasks_checked_o !== 8'd1) $display("FAIL t1_tasks: got %0d want 1", tasks_checked_o); else n_pass++;
    n_chk++; if (snap_reqs - s0 !== 2) $display("FAIL t1_compares: got %0d want 2", snap_reqs - s0); else n_pass++;
  endtask

  task automatic test_burst_mismatch();
    bit ok;
    init_mem(); fixed_dly = 0;
    put_desc(0, 32'd1, 32'h10, 32'd64, 32'h80);
    copy_words(2, 16, 8);
    live_mem[17] = live_mem[17] ^ 64'h1;
    run(32'h0, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t2_done: no done_o within budget"); else n_pass++;
    n_chk++; if (fail_count_o !== 16'd1) $display("FAIL t2_cnt: got %0d want 1", fail_count_o); else n_pass++;
    n_chk++; if (err_code_o !== 3'd1) $display("FAIL t2_err: got %0d want 1", err_code_o); else n_pass++;
    n_chk++; if (fail_addr_o !== 32'h11) $display("FAIL t2_addr: got %0h want 11", fail_addr_o); else n_pass++;
    n_chk++; if (pass_o !== 1'b0) $display("FAIL t2_pass: got %b want 0", pass_o); else n_pass++;
  endtask

  task automatic test_chain();
    bit ok;
    init_mem(); fixed_dly = 2;
    put_desc(0, 32'd2, 32'h60, 32'd8,  32'hA0);
    put_desc(4, 32'd2, 32'h68, 32'd16, 32'hA8);
    put_desc(8, 32'd0, 32'h78, 32'd8,  32'hC0);
    copy_words(12, 20, 1); copy_words(13, 21, 2); copy_words(15, 24, 1);
    run(32'h0, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t3_done: no done_o within budget"); else n_pass++;
    n_chk++; if (tasks_checked_o !== 8'd3) $display("FAIL t3_tasks: got %0d want 3", tasks_checked_o); else n_pass++;
    n_chk++; if (pass_o !== 1'b1) $display("FAIL t3_pass: got %b want 1", pass_o); else n_pass++;
    n_chk++; if (fail_count_o !== 16'd0) $display("FAIL t3_cnt: got %0d want 0", fail_count_o); else n_pass++;
  endtask

  task automatic test_range();
    bit ok; int s0;
    init_mem(); fixed_dly = 0;
    put_desc(0, 32'd0, 32'hF0, 32'd32, 32'h80);
    live_mem[31] = 64'd1;
    s0 = snap_reqs;
    run(32'h0, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t4a_done: no done_o within budget"); else n_pass++;
    n_chk++; if (pass_o !== 1'b1) $display("FAIL t4a_pass: got %b want 1", pass_o); else n_pass++;
    n_chk++; if (snap_reqs - s0 !== 0) $display("FAIL t4a_compares: got %0d want 0", snap_reqs - s0); else n_pass++;
    live_mem[31] = 64'd0;
    run(32'h0, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t4b_done: no done_o within budget"); else n_pass++;
    n_chk++; if (err_code_o !== 3'd5) $display("FAIL t4b_err: got %0d want 5", err_code_o); else n_pass++;
    n_chk++; if (fail_addr_o !== 32'd31) $display("FAIL t4b_addr: got %0d want 31", fail_addr_o); else n_pass++;
    n_chk++; if (pass_o !== 1'b0) $display("FAIL t4b_pass: got %b want 0", pass_o); else n_pass++;
  endtask

  // Every fourth word holds a link descriptor; word 32 wraps onto word 0.
  task automatic test_chain_too_long();
    bit ok;
    init_mem(); fixed_dly = 0;
    for (int w = 0; w < 32; w += 4) put_desc(w, 32'd2, 32'h0, 32'd0, 32'h0);
    run(32'h0, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t5_done: no done_o within budget"); else n_pass++;
    n_chk++; if (err_code_o !== 3'd4) $display("FAIL t5_err: got %0d want 4", err_code_o); else n_pass++;
    n_chk++; if (tasks_checked_o !== 8'd8) $display("FAIL t5_tasks: got %0d want 8", tasks_checked_o); else n_pass++;
    n_chk++; if (fail_addr_o !== 32'd32) $display("FAIL t5_addr: got %0d want 32", fail_addr_o); else n_pass++;
  endtask

  task automatic test_bad_desc();
    bit ok;
    init_mem(); fixed_dly = 0;
    put_desc(8, 32'd3, 32'h0, 32'd0, 32'h0);
    run(32'h40, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t7_done: no done_o within budget"); else n_pass++;
    n_chk++; if (err_code_o !== 3'd2) $display("FAIL t7_type_err: got %0d want 2", err_code_o); else n_pass++;
    n_chk++; if (fail_addr_o !== 32'd8) $display("FAIL t7_type_addr: got %0d want 8", fail_addr_o); else n_pass++;
    put_desc(4, 32'd0, 32'h14, 32'd8, 32'h80);
    run(32'h20, 32'd31, ok);
    n_chk++; if (!ok) $display("FAIL t8_done: no done_o within budget"); else n_pass++;
    n_chk++; if (err_code_o !== 3'd3) $display("FAIL t8_align_err: got %0d want 3", err_code_o); else n_pass++;
    n_chk++; if (fail_addr_o !== 32'd4) $display("FAIL t8_align_addr: got %0d want 4", fail_addr_o); else n_pass++;
  endtask

  task automatic test_skew_reset();
    bit ok, seen; int s0;
    setup_case1();
    skew = 1'b1;
    for (int r = 0; r < 3; r++) begin
      s0 = snap_reqs;
      run(32'h0, 32'd31, ok);
      n_chk++; if (!ok) $display("FAIL t6_done%0d: no done_o within budget", r); else n_pass++;
      n_chk++; if ({pass_o, err_code_o, tasks_checked_o} !== {1'b1, 3'd0, 8'd1})
        $display("FAIL t6_result%0d: got pass %b err %0d tasks %0d want 1/0/1", r, pass_o, err_code_o, tasks_checked_o); else n_pass++;
      n_chk++; if (snap_reqs - s0 !== 2) $display("FAIL t6_compares%0d: got %0d want 2", r, snap_reqs - s0); else n_pass++;
    end
    skew = 1'b0; fixed_dly = 6;
    @(negedge clk);
    task_pointer_i = 32'h0; status_pointer_i = 32'd31; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (snap_req_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_chk++; if (!seen) $display("FAIL t6_reach_cmp: snap_req_o never rose"); else n_pass++;
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({live_req_o, snap_req_o, busy_o, done_o, pass_o} !== 5'b0)
      $display("FAIL t6_rst_ctrl: got %b want 00000", {live_req_o, snap_req_o, busy_o, done_o, pass_o}); else n_pass++;
    n_chk++; if ({err_code_o, fail_count_o, tasks_checked_o} !== 27'd0)
      $display("FAIL t6_rst_stat: got err %0d cnt %0d tasks %0d want 0", err_code_o, fail_count_o, tasks_checked_o); else n_pass++;
    n_chk++; if ({live_addr_o, snap_addr_o, fail_addr_o} !== 96'd0)
      $display("FAIL t6_rst_addr: got %0h %0h %0h want 0", live_addr_o, snap_addr_o, fail_addr_o); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    fixed_dly = 1;
    run(32'h0, 32'd31, ok);
    n_chk++; if (!ok || pass_o !== 1'b1 || tasks_checked_o !== 8'd1)
      $display("FAIL t6_recover: got done %b pass %b tasks %0d want 1/1/1", ok, pass_o, tasks_checked_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_mismatch();
    test_chain();
    test_range();
    test_chain_too_long();
    test_bad_desc();
    test_skew_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
